// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types: RV32 opcodes, instruction field positions and the FIFO entry layout.
package instr_fetch_unit_pkg;

  localparam int XLEN               = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int FIFO_DEPTH_DEFAULT = 2;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_I      = 7'h13,
    OP_STORE  = 7'h23,
    OP_R      = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63
  } opcode_e;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_fields_t;

  // pc in the upper half so the raw 64-bit FIFO word reads as {pc, instr}
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic instr_fields_t split_instr(input logic [XLEN-1:0] w);
    instr_fields_t f;
    f.opcode = w[OPCODE_LSB +: 7];
    f.rd     = w[RD_LSB     +: 5];
    f.funct3 = w[FUNCT3_LSB +: 3];
    f.rs1    = w[RS1_LSB    +: 5];
    f.rs2    = w[RS2_LSB    +: 5];
    f.funct7 = w[FUNCT7_LSB +: 7];
    return f;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/response, ControlUnit redirect/stall and the decoded head.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;

  modport master (
    output imem_req_valid, imem_req_addr,
    output instr_valid, instr, instr_pc, opcode, rd, funct3, rs1, rs2, funct7,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  instr_valid, instr, instr_pc, opcode, rd, funct3, rs1, rs2, funct7,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, stall
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with registered storage, flush and occupancy count; head is a direct storage read.
// Push while full is accepted only together with a pop; flush takes priority over push/pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, credit-limited in-order imem requests, tag/instruction buffers, field split.
// Redirect flushes the buffer and drops responses still in flight for the wrong path.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_d, pc_q;
  logic [CW-1:0]   inflight_d, inflight_q;
  logic [CW-1:0]   drop_d, drop_q;
  logic            active_q;

  logic [CW-1:0]   ibuf_count, tag_count;
  logic            ibuf_full, ibuf_empty, tag_full, tag_empty;
  logic [2*XLEN-1:0] ibuf_head_dat;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  instr_fields_t   fields;

  logic            accept, resp, keep, pop;
  logic [CW:0]     credit_used;

  assign pop = ~ibuf_empty & ~bus.stall;

  // A slot freed by this cycle's pop is credited immediately so latency-1 memory streams at 1 instr/cycle.
  assign credit_used = {1'b0, inflight_q} + {1'b0, ibuf_count} - {{CW{1'b0}}, pop};

  assign bus.imem_req_valid = active_q & ~bus.redirect_valid
                            & (credit_used < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_req_addr  = pc_q;

  assign accept = bus.imem_req_valid & bus.imem_req_ready;
  assign resp   = bus.imem_resp_valid;
  assign keep   = resp & (drop_q == '0) & ~bus.redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(accept) - CW'(resp);
    drop_d     = drop_q;
    if (bus.redirect_valid) begin
      pc_d   = bus.redirect_pc & PC_ALIGN_MASK;
      drop_d = inflight_q - CW'(resp);
    end else begin
      if (accept) pc_d = pc_q + XLEN'(4);
      if (resp && drop_q != '0) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC & PC_ALIGN_MASK;
      inflight_q <= '0;
      drop_q     <= '0;
      active_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      active_q   <= 1'b1;
    end
  end

  // PCs of accepted requests; popped only by responses that are kept.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (accept),
    .push_dat_i (pc_q),
    .pop_i      (keep),
    .flush_i    (bus.redirect_valid),
    .head_dat_o (tag_pc),
    .count_o    (tag_count),
    .full_o     (tag_full),
    .empty_o    (tag_empty)
  );

  assign push_entry.pc    = tag_pc;
  assign push_entry.instr = bus.imem_resp_data;

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (keep),
    .push_dat_i (push_entry),
    .pop_i      (pop),
    .flush_i    (bus.redirect_valid),
    .head_dat_o (ibuf_head_dat),
    .count_o    (ibuf_count),
    .full_o     (ibuf_full),
    .empty_o    (ibuf_empty)
  );

  assign head   = fetch_entry_t'(ibuf_head_dat);
  assign fields = split_instr(head.instr);

  assign bus.instr_valid = ~ibuf_empty;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.opcode      = fields.opcode;
  assign bus.rd          = fields.rd;
  assign bus.funct3      = fields.funct3;
  assign bus.rs1         = fields.rs1;
  assign bus.rs2         = fields.rs2;
  assign bus.funct7      = fields.funct7;

  a_inflight_bound: assert property (@(posedge clk) disable iff (!rst_n)
    inflight_q <= CW'(FIFO_DEPTH));
  a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
    drop_q <= CW'(FIFO_DEPTH));
  a_tags_match: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count == inflight_q - drop_q);
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(accept && tag_full));
  a_tag_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(keep && tag_empty));
  a_ibuf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(keep && ibuf_full && !pop));

endmodule
